// File: rtl/audio_return_if.sv
// audio_return_if
//   Connects the audio return transmitter to the host-side pins and to the
//   effect-path sample source.
//   master : host/sample-source side (drives SPI pins and the push strobe)
//   slave  : transmitter side (drives MISO, occupancy and status pulses)
//   Signals:
//     sclk_in, active       host SPI clock and frame select (asynchronous)
//     sample_in/valid       16-bit two's-complement sample and push strobe
//     miso_out              serial data to the host
//     fifo_count            sample FIFO occupancy
//     overflow/underrun     one-cycle status pulses
//     frame_done            one-cycle pulse after 16 bits were clocked out
interface audio_return_if #(
  parameter int FIFO_DEPTH = 4
);
  logic                                 sclk_in;
  logic                                 active;
  logic signed [15:0]                   sample_in;
  logic                                 sample_valid;
  logic                                 miso_out;
  logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count;
  logic                                 overflow;
  logic                                 underrun;
  logic                                 frame_done;

  modport master (
    output sclk_in, active, sample_in, sample_valid,
    input  miso_out, fifo_count, overflow, underrun, frame_done
  );

  modport slave (
    input  sclk_in, active, sample_in, sample_valid,
    output miso_out, fifo_count, overflow, underrun, frame_done
  );
endinterface

// File: rtl/audio_return_tx.sv
// audio_return_tx
//   SPI mode-0 slave transmitter returning processed 16-bit audio samples to
//   the host on MISO, MSB first. Samples are pushed into a small circular
//   FIFO on the system clock; each host frame (active high) pops one sample
//   into a shift register that is clocked out by the host SCLK.
//   Ports:
//     clk_25mhz  system clock, all logic on its rising edge
//     reset      synchronous active-high reset
//     bus        audio_return_if.slave (SPI pins, sample push, status)
module audio_return_tx #(
  parameter int clock_max  = 25_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk_25mhz,
  input  logic          reset,
  audio_return_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (clock_max < 8)) begin : g_bad_param
    $error("audio_return_tx: FIFO_DEPTH must be a power of two >= 2 and clock_max >= 8");
  end

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  // Pin synchronizers and edge detectors. These carry no reset on purpose:
  // a reset while the host holds active high must not manufacture a fresh
  // active rising edge once reset releases.
  logic [1:0] r_sclk_sync;
  logic [1:0] r_act_sync;
  logic       r_sclk_dly;
  logic       r_act_dly;

  always_ff @(posedge clk_25mhz) begin
    r_sclk_sync <= {r_sclk_sync[0], bus.sclk_in};
    r_act_sync  <= {r_act_sync[0], bus.active};
    r_sclk_dly  <= r_sclk_sync[1];
    r_act_dly   <= r_act_sync[1];
  end

  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_act_rise;
  logic w_act_fall;

  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_dly;
  assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_dly;
  assign w_act_rise  = r_act_sync[1] & ~r_act_dly;
  assign w_act_fall  = ~r_act_sync[1] & r_act_dly;

  // Sample FIFO
  logic signed [15:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               r_overflow;
  state_t             r_state;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push_ok;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_pop     = (r_state == LOAD) && !w_empty;
  // A pop in the same cycle frees the slot the push needs.
  assign w_push_ok = bus.sample_valid && (!w_full || w_pop);

  always_ff @(posedge clk_25mhz) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= bus.sample_in;
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= bus.sample_valid && !w_push_ok;
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      unique case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame state machine
  logic signed [15:0] r_shift;
  logic [4:0]         r_bit_cnt;
  logic               r_miso;
  logic               r_underrun;
  logic               r_frame_done;

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_miso       <= 1'b0;
      r_underrun   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_underrun   <= 1'b0;
      r_frame_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_miso    <= 1'b0;
          r_bit_cnt <= '0;
          if (w_act_rise) begin
            r_state <= LOAD;
          end
        end
        LOAD: begin
          // The pop happens here even if the frame is aborted; the sample is lost.
          r_shift    <= w_pop ? r_mem[r_rd_ptr] : 16'sh0000;
          r_underrun <= w_empty;
          r_bit_cnt  <= '0;
          r_state    <= w_act_fall ? IDLE : SHIFT;
        end
        SHIFT: begin
          // MISO trails the shift register by one cycle.
          r_miso <= r_shift[15];
          if (w_act_fall) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_miso    <= 1'b0;
          end else if (w_sclk_rise) begin
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd15) begin
              r_state      <= DONE;
              r_frame_done <= 1'b1;
            end
          end else if (w_sclk_fall && (r_bit_cnt < 5'd16)) begin
            r_shift <= {r_shift[14:0], 1'b0};
          end
        end
        DONE: begin
          if (w_act_fall) begin
            r_state <= IDLE;
            r_miso  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.miso_out   = r_miso;
  assign bus.fifo_count = r_count;
  assign bus.overflow   = r_overflow;
  assign bus.underrun   = r_underrun;
  assign bus.frame_done = r_frame_done;

endmodule
